// File: rtl/pipelined_adder.sv
// Pipelined ripple adder/subtractor: WIDTH bits split into STAGES equal slices,
// one slice per stage, with a valid/ready handshake and a stall-able pipeline.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int SW = WIDTH / STAGES;

  logic             advance_s;
  logic [WIDTH-1:0] beff_s;
  logic             c0_s;

  assign advance_s  = ~out_valid_o | out_ready_i;
  assign in_ready_o = advance_s;
  assign beff_s     = sub_i ? ~b_i : b_i;
  assign c0_s       = sub_i ? 1'b1 : cin_i;

  // Stage k holds the low (k+1)*SW result bits plus the operand bits not yet added.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SW;
    localparam int HI = (k + 1) * SW;

    logic [SW-1:0] a_sl_s;
    logic [SW-1:0] b_sl_s;
    logic          c_in_s;
    logic          v_in_s;
    logic [SW:0]   add_s;
    logic [HI-1:0] s_nx_s;

    logic          vld_r;
    logic          c_r;
    logic [HI-1:0] s_r;

    if (k == 0) begin : g_src
      assign a_sl_s = a_i[SW-1:0];
      assign b_sl_s = beff_s[SW-1:0];
      assign c_in_s = c0_s;
      assign v_in_s = in_valid_i;
      assign s_nx_s = add_s[SW-1:0];
    end else begin : g_src
      assign a_sl_s = g_stage[k-1].g_ops.a_r[HI-1:LO];
      assign b_sl_s = g_stage[k-1].g_ops.b_r[HI-1:LO];
      assign c_in_s = g_stage[k-1].c_r;
      assign v_in_s = g_stage[k-1].vld_r;
      assign s_nx_s = {add_s[SW-1:0], g_stage[k-1].s_r};
    end

    assign add_s = {1'b0, a_sl_s} + {1'b0, b_sl_s} + {{SW{1'b0}}, c_in_s};

    // Slice result, carry and valid advance together; all hold on a stall.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        vld_r <= 1'b0;
        c_r   <= 1'b0;
        s_r   <= {HI{1'b0}};
      end else if (advance_s) begin
        vld_r <= v_in_s;
        c_r   <= add_s[SW];
        s_r   <= s_nx_s;
      end
    end

    if (k < STAGES - 1) begin : g_ops
      logic [WIDTH-1:HI] a_up_s;
      logic [WIDTH-1:HI] b_up_s;
      logic [WIDTH-1:HI] a_r;
      logic [WIDTH-1:HI] b_r;

      if (k == 0) begin : g_up
        assign a_up_s = a_i[WIDTH-1:HI];
        assign b_up_s = beff_s[WIDTH-1:HI];
      end else begin : g_up
        assign a_up_s = g_stage[k-1].g_ops.a_r[WIDTH-1:HI];
        assign b_up_s = g_stage[k-1].g_ops.b_r[WIDTH-1:HI];
      end

      // Delay line for the operand slices later stages still need.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          a_r <= {(WIDTH-HI){1'b0}};
          b_r <= {(WIDTH-HI){1'b0}};
        end else if (advance_s) begin
          a_r <= a_up_s;
          b_r <= b_up_s;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_s;
      logic ovf_r;

      assign ovf_s = (a_sl_s[SW-1] == b_sl_s[SW-1]) & (add_s[SW-1] != a_sl_s[SW-1]);

      // Signed overflow is only known once the top slice is added.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          ovf_r <= 1'b0;
        end else if (advance_s) begin
          ovf_r <= ovf_s;
        end
      end
    end
  end

  assign out_valid_o = g_stage[STAGES-1].vld_r;
  assign sum_o       = g_stage[STAGES-1].s_r;
  assign cout_o      = g_stage[STAGES-1].c_r;
  assign ovf_o       = g_stage[STAGES-1].g_last.ovf_r;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=32, STAGES=4): expected results
// are queued at acceptance and compared when the DUT delivers them.
module tb_pipelined_adder;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  txn_t        stim_q[$];
  logic [33:0] exp_q[$];
  int          acc_q[$];

  int n_tests   = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int n_out     = 0;
  bit lat_chk   = 1'b0;
  bit stall_chk = 1'b0;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .a_i        (a),
    .b_i        (b),
    .cin_i      (cin),
    .sub_i      (sub),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .sum_o      (sum),
    .cout_o     (cout),
    .ovf_o      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference result {sum, cout, ovf} from full-width arithmetic.
  function automatic logic [33:0] model(input txn_t t);
    logic [31:0] be;
    logic [32:0] r;
    logic        v;
    be = t.sub ? ~t.b : t.b;
    r  = {1'b0, t.a} + {1'b0, be} + {32'd0, (t.sub ? 1'b1 : t.cin)};
    v  = (t.a[31] == be[31]) && (r[31] != t.a[31]);
    return {r[31:0], r[32], v};
  endfunction

  function automatic txn_t mk(input logic [31:0] ta, input logic [31:0] tb,
                              input logic tcin, input logic tsub);
    txn_t t;
    t.a = ta; t.b = tb; t.cin = tcin; t.sub = tsub;
    return t;
  endfunction

  function automatic txn_t rnd();
    return mk($urandom(), $urandom(), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
  endfunction

  // One cycle: drive at the falling edge, sample 1 ns later, well before the rising edge.
  task automatic tick();
    txn_t        t;
    logic [33:0] e;
    int          ac;
    if (stim_q.size() > 0) begin
      t = stim_q[0];
      in_valid = 1'b1;
    end else begin
      t = rnd();
      in_valid = 1'b0;
    end
    a = t.a; b = t.b; cin = t.cin; sub = t.sub;
    #1;
    if (stall_chk) check("stall_in_ready", {63'd0, in_ready}, 64'd0);
    if (exp_q.size() == 0) begin
      check("no_spurious_out", {63'd0, out_valid}, 64'd0);
    end else if (out_valid && out_ready) begin
      e  = exp_q.pop_front();
      ac = acc_q.pop_front();
      n_out++;
      check("result", {30'd0, sum, cout, ovf}, {30'd0, e});
      if (lat_chk) check("latency", 64'(cyc - ac), 64'(STAGES));
    end else if (out_valid) begin
      check("held_result", {30'd0, sum, cout, ovf}, {30'd0, exp_q[0]});
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(t));
      acc_q.push_back(cyc);
      void'(stim_q.pop_front());
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // Asynchronous reset with no clock edge yet.
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_sum",       {32'd0, sum},       64'd0);
    check("rst_cout",      {63'd0, cout},      64'd0);
    check("rst_ovf",       {63'd0, ovf},       64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed corners, accepted back to back.
    lat_chk = 1'b1;
    stim_q.push_back(mk(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0));
    stim_q.push_back(mk(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0));
    stim_q.push_back(mk(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1));
    stim_q.push_back(mk(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1));
    stim_q.push_back(mk(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0));
    run(10);
    check("directed_drain", 64'(exp_q.size() + stim_q.size()), 64'd0);

    // Ten back-to-back random transactions.
    base = n_out;
    for (int i = 0; i < 10; i++) stim_q.push_back(rnd());
    run(16);
    check("b2b_count", 64'(n_out - base), 64'd10);

    // Fill the pipeline with output blocked, stall three cycles, then drain.
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    base      = n_out;
    for (int i = 0; i < 6; i++) stim_q.push_back(rnd());
    run(4);
    stall_chk = 1'b1;
    run(3);
    stall_chk = 1'b0;
    out_ready = 1'b1;
    run(12);
    check("stall_count", 64'(n_out - base), 64'd6);
    check("stall_drain", 64'(exp_q.size() + stim_q.size()), 64'd0);

    // Reset with three transactions in flight; nothing stale may emerge.
    lat_chk = 1'b1;
    for (int i = 0; i < 3; i++) stim_q.push_back(rnd());
    run(3);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_in_ready",  {63'd0, in_ready},  64'd1);
    exp_q.delete();
    acc_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    stim_q.push_back(mk(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0));
    run(10);
    check("post_rst_drain", 64'(exp_q.size() + stim_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (legal: 4..128).
REQ-002 The block SHALL have parameter STAGES, default 4, meaning the number of pipeline stages (legal: 1..WIDTH, WIDTH mod STAGES == 0), each stage handling WIDTH/STAGES bits.
REQ-003 The block SHALL have port clk_i, input, 1 bit, the single clock; all flops are rising-edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit, the reset: asynchronous, active-high.
REQ-005 The block SHALL have port in_valid_i, input, 1 bit, meaning an operand pair is offered.
REQ-006 The block SHALL have port in_ready_o, output, 1 bit, meaning the block accepts the offered pair this cycle.
REQ-007 The block SHALL have port a_i, input, WIDTH bits, operand A.
REQ-008 The block SHALL have port b_i, input, WIDTH bits, operand B.
REQ-009 The block SHALL have port cin_i, input, 1 bit, carry-in (add mode only).
REQ-010 The block SHALL have port sub_i, input, 1 bit, mode select: 0 = A+B+cin_i, 1 = A-B.
REQ-011 The block SHALL have port out_valid_o, output, 1 bit, meaning the result ports hold a valid result.
REQ-012 The block SHALL have port out_ready_i, input, 1 bit, meaning downstream consumes the result this cycle.
REQ-013 The block SHALL have port sum_o, output, WIDTH bits, the result.
REQ-014 The block SHALL have port cout_o, output, 1 bit, the unsigned carry-out (borrow-not in sub mode).
REQ-015 The block SHALL have port ovf_o, output, 1 bit, the two's-complement signed overflow flag.

Function
REQ-016 The block SHALL accept a transaction in a cycle where in_valid_i and in_ready_o are both 1; all inputs are sampled only in that cycle.
REQ-017 The block SHALL define advance = !out_valid_o | out_ready_i; in_ready_o SHALL equal advance (combinational, no dependency on in_valid_i).
REQ-018 The block SHALL shift all stages by one position when advance is 1 and hold every stage register unchanged when advance is 0.
REQ-019 The block SHALL insert a bubble (valid bit 0) into stage 0 when advance is 1 and in_valid_i is 0.
REQ-020 The block SHALL present an accepted transaction on the outputs exactly STAGES cycles after acceptance when no stall occurs; each stall cycle adds one cycle.
REQ-021 The block SHALL, in stage k, add bit slice k of the operands using the carry registered by stage k-1 (stage 0 uses the mode carry-in), and SHALL register the slice sum, carry and the delayed upper operand slices.
REQ-022 The block SHALL, in sub mode, use ~b_i as the B operand and a carry-in of 1, ignoring cin_i; in add mode it SHALL use b_i and cin_i.
REQ-023 The block SHALL set sum_o to (A + B' + c0) mod 2^WIDTH and cout_o to the carry out of bit WIDTH-1.
REQ-024 The block SHALL set ovf_o = (A[MSB] == B'[MSB]) & (sum_o[MSB] != A[MSB]), with B' the effective (possibly inverted) operand.
REQ-025 The block SHALL keep results in order, with no drop or duplication; a result held under !out_ready_i SHALL stay stable on all output ports.
REQ-026 The block SHALL, with STAGES = 1, behave as a single registered adder with latency 1 and the same handshake.
REQ-027 The block SHALL sustain one transaction per cycle with out_ready_i held at 1.

Reset
REQ-028 The block SHALL, while rst_i is 1, immediately clear all stage valid bits, sum_o, cout_o, ovf_o and out_valid_o to 0, independent of clk_i.
REQ-029 The block SHALL discard in-flight transactions on reset mid-operation; in_ready_o SHALL be 1 during and after reset.
REQ-030 The block SHALL accept a transaction on the first rising edge after rst_i falls.

Verification (WIDTH=32, STAGES=4)
REQ-031 Verification SHALL cover: add, a=0xFFFFFFFF, b=0x00000001, cin=0 -> 4 cycles later sum=0x00000000, cout=1, ovf=0 (full-width carry ripple across all stages).
REQ-032 Verification SHALL cover: add, a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, cout=0, ovf=1; then sub, a=0x80000000, b=0x00000001 -> sum=0x7FFFFFFF, cout=1, ovf=1.
REQ-033 Verification SHALL cover: sub, a=5, b=7, cin_i=1 -> sum=0xFFFFFFFE, cout=0, ovf=0 (cin_i ignored in sub mode).
REQ-034 Verification SHALL cover: 10 back-to-back transactions with out_ready_i=1 -> 10 results on consecutive cycles, in order, first result 4 cycles after the first acceptance.
REQ-035 Verification SHALL cover: pipeline full, out_ready_i=0 for 3 cycles -> in_ready_o=0, outputs stable, no loss; on release all results drain in order.
REQ-036 Verification SHALL cover: rst_i asserted asynchronously with 3 transactions in flight -> out_valid_o=0 at once, no stale result emerges after reset release.
